data_ram: RTL and testbench
===========================

Name: data_ram

Overview:
- Data-memory responder at the far end of the MEM-stage data RAM interface.
- Accepts chip-enable/write-enable/byte-select/address/data requests from the MEM stage.
- Performs byte-lane writes and full-word reads against an internal word array.
- Models a configurable number of wait states; requests the pipeline stall while an access is pending.

Parameters:
- ADDR_WIDTH, 10, word-index bits; array depth = 2**ADDR_WIDTH 32-bit words.
- WAIT_STATES, 1, busy cycles per access; 0 selects the zero-wait combinational-read mode.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce_i  in  1  chip enable; 1 = request present.
- we_i  in  1  1 = write, 0 = read.
- sel_i  in  4  byte-lane enables; bit i ↔ data bits [8i+7:8i].
- addr_i  in  32  byte address; word index = addr_i[ADDR_WIDTH+1:2]; bits [1:0] and above ADDR_WIDTH+1 ignored (aliasing).
- data_i  in  32  write data.
- data_o  out  32  read data.
- stallreq_o  out  1  1 = access pending; hold the pipeline.
- align_err_o  out  1  illegal byte-select flag (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; stallreq_o=0, data_o=0, align_err_o=0.
  - Counter and latched request cleared; any pending write discarded.
  - Array contents not reset.
- FSM states (WAIT_STATES>=1): IDLE, BUSY, DONE.
- IDLE:
  - If ce_i=1: latch we_i/sel_i/word index/data_i; load counter=WAIT_STATES; stallreq_o=1 combinationally this cycle; go BUSY.
  - If ce_i=0: stallreq_o=0; stay IDLE.
- BUSY:
  - stallreq_o=1; counter decrements each cycle.
  - In the cycle counter==1, at the clock edge:
    - write: array[idx] byte lanes with sel=1 take latched data; other lanes unchanged.
    - read: data_o <= array[idx] (full word, sel ignored).
  - Then go DONE.
  - BUSY lasts exactly WAIT_STATES cycles.
- DONE:
  - stallreq_o=0; data_o valid for a read; pipeline advances at the end of this cycle.
  - Always return to IDLE; a ce_i seen in the following IDLE cycle is a new request.
- Total stall: WAIT_STATES+1 cycles per access (accept cycle + BUSY cycles); result visible in cycle WAIT_STATES+1 after acceptance.
- Inputs changing during BUSY/DONE are ignored; the latched request completes even if ce_i drops.
- data_o holds the last captured read value outside DONE; writes do not alter data_o.
- sel_i=0 write: legal no-op; array unchanged; still takes full latency.
- WAIT_STATES=0:
  - No FSM; stallreq_o tied 0.
  - data_o = array[idx] combinationally when ce_i=1 & we_i=0, else 0.
  - Write at the rising edge when ce_i=1 & we_i=1.
  - Read of the same word in the cycle of a write returns old contents.
- Reset asserted mid-BUSY: write not committed, read data not captured; stallreq_o drops immediately (async).

Optional Feature:
- Macro DATA_RAM_ALIGN_CHECK_EN.
- Defined:
  - Legal sel_i patterns: 0001, 0010, 0100, 1000, 0011, 1100, 1111 (reads: any nonzero).
  - Illegal write pattern: write suppressed; align_err_o=1 for exactly the DONE cycle (WAIT_STATES=0: the request cycle, combinational).
  - Reads with sel_i=0 also flag.
- Undefined: all sel patterns honoured as given; align_err_o tied 0.

Test Plan:
- Reset then idle, WAIT_STATES=1: rst pulse, ce_i=0 for 5 cycles -> stallreq_o=0, data_o=0 throughout.
- Write-then-read, WAIT_STATES=1:
  - Write addr=0x10, data=0xDEADBEEF, sel=1111 -> stallreq_o=1 for 2 cycles, 0 in DONE.
  - Read addr=0x10 -> data_o=0xDEADBEEF in its DONE cycle.
- Byte lanes: word 0x20 = 0x11223344; write sel=0100, data=0xAABBCCDD -> read returns 0x11BB3344. Aliasing: addr=0x20+(1<<(ADDR_WIDTH+2)) reads the same word.
- Latency sweep, WAIT_STATES=3: read request -> stallreq_o high exactly 4 cycles; ce_i dropped in BUSY -> access still completes, correct data_o.
- Reset mid-BUSY: write 0x12345678 to 0x40 over old 0x0, rst asserted in BUSY -> stallreq_o=0 immediately; read 0x40 afterwards returns 0x0.
- DATA_RAM_ALIGN_CHECK_EN defined: write sel=0101 to 0x50 holding 0xCAFEF00D -> align_err_o=1 in DONE only; word still 0xCAFEF00D. Macro undefined: same write gives 0xCA??F0?? lanes updated, align_err_o=0.

Source files
------------

// File: rtl/data_ram.sv
// rtl/data_ram.sv - wait-state data RAM responder; DATA_RAM_ALIGN_CHECK_EN enables byte-select legality checking
module data_ram #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stallreq_o,
    output logic        align_err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic                  req_bad;
    logic                  unused_bits;

    assign idx         = addr_i[ADDR_WIDTH+1:2];
    assign unused_bits = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0], rst};

`ifdef DATA_RAM_ALIGN_CHECK_EN
    always_comb begin
        req_bad = 1'b0;
        if (we_i) begin
            case (sel_i)
                4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0011, 4'b1100, 4'b1111: req_bad = 1'b0;
                default:                   req_bad = 1'b1;
            endcase
        end else begin
            req_bad = (sel_i == 4'b0000);
        end
    end
`else
    assign req_bad = 1'b0;
`endif

    generate
        if (WAIT_STATES == 0) begin : g_zero
            // Combinational read returns pre-write contents; the write lands at the edge.
            assign stallreq_o  = 1'b0;
            assign data_o      = (ce_i && !we_i) ? mem[idx] : 32'h0;
            assign align_err_o = ce_i & req_bad;

            always_ff @(posedge clk) begin
                if (ce_i && we_i && !req_bad) begin
                    for (int i = 0; i < 4; i++) begin
                        if (sel_i[i]) mem[idx][8*i +: 8] <= data_i[8*i +: 8];
                    end
                end
            end
        end else begin : g_fsm
            typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

            state_t                state, state_nxt;
            logic [CW-1:0]         cnt, cnt_nxt;
            logic                  lat_we, lat_bad;
            logic [3:0]            lat_sel;
            logic [ADDR_WIDTH-1:0] lat_idx;
            logic [31:0]           lat_data;
            logic [31:0]           rdata_q;
            logic                  commit, stall, aerr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state    <= IDLE;
                    cnt      <= '0;
                    lat_we   <= 1'b0;
                    lat_bad  <= 1'b0;
                    lat_sel  <= '0;
                    lat_idx  <= '0;
                    lat_data <= '0;
                    rdata_q  <= '0;
                end else begin
                    state <= state_nxt;
                    cnt   <= cnt_nxt;
                    if (state == IDLE && ce_i) begin
                        lat_we   <= we_i;
                        lat_bad  <= req_bad;
                        lat_sel  <= sel_i;
                        lat_idx  <= idx;
                        lat_data <= data_i;
                    end
                    if (commit && !lat_we) rdata_q <= mem[lat_idx];
                end
            end

            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                commit    = 1'b0;
                stall     = 1'b0;
                aerr      = 1'b0;
                case (state)
                    IDLE: begin
                        if (ce_i) begin
                            stall     = 1'b1;
                            cnt_nxt   = CW'(WAIT_STATES);
                            state_nxt = BUSY;
                        end
                    end
                    BUSY: begin
                        stall   = 1'b1;
                        cnt_nxt = cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            commit    = 1'b1;
                            state_nxt = DONE;
                        end
                    end
                    DONE: begin
                        aerr      = lat_bad;
                        state_nxt = IDLE;
                    end
                    default: state_nxt = IDLE;
                endcase
            end

            // The accept-cycle stall is combinational, so gate it so reset drops it at once.
            assign stallreq_o  = stall & ~rst;
            assign align_err_o = aerr;
            assign data_o      = rdata_q;

            always_ff @(posedge clk) begin
                if (commit && lat_we && !lat_bad) begin
                    for (int i = 0; i < 4; i++) begin
                        if (lat_sel[i]) mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - scoreboard bench for data_ram at WAIT_STATES 1, 3 and 0
module tb_data_ram;

    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce    [3];
    logic        we    [3];
    logic [3:0]  sel   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        stall [3];
    logic        aerr  [3];

    int          checks   = 0;
    int          failures = 0;
    bit          align_en;
    logic [31:0] model [3][1 << AW];
    logic [31:0] last_rd [3];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    data_ram #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .sel_i(sel[0]), .addr_i(addr[0]),
        .data_i(wdata[0]), .data_o(rdata[0]), .stallreq_o(stall[0]), .align_err_o(aerr[0]));

    data_ram #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .sel_i(sel[1]), .addr_i(addr[1]),
        .data_i(wdata[1]), .data_o(rdata[1]), .stallreq_o(stall[1]), .align_err_o(aerr[1]));

    data_ram #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .ce_i(ce[2]), .we_i(we[2]), .sel_i(sel[2]), .addr_i(addr[2]),
        .data_i(wdata[2]), .data_o(rdata[2]), .stallreq_o(stall[2]), .align_err_o(aerr[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic illegal(input logic w, input logic [3:0] s);
        if (!align_en) return 1'b0;
        if (!w) return (s == 4'b0000);
        return !(s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    endfunction

    // Called at a falling edge; returns at the falling edge after the access completes.
    task automatic access(input int d, input logic w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] dat, input string tag);
        int          ws;
        int          cyc;
        int          widx;
        bit          done;
        logic [31:0] exp;
        ws   = (d == 0) ? 1 : ((d == 1) ? 3 : 0);
        widx = int'(a[AW+1:2]);
        ce[d] = 1'b1; we[d] = w; sel[d] = s; addr[d] = a; wdata[d] = dat;
        if (!w) exp_q.push_back(model[d][widx]);
        cyc  = 0;
        done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!stall[d]) begin
                done = 1'b1;
                break;
            end
            cyc++;
            @(negedge clk);
            if (k == 0) begin
                ce[d] = 1'b0; we[d] = ~w; sel[d] = 4'($urandom);
                addr[d] = $urandom; wdata[d] = $urandom;
            end
        end
        check({tag, " completes"}, 32'(done), 32'd1);
        check({tag, " stall_cycles"}, cyc, (ws == 0) ? 0 : ws + 1);
        if (!w) begin
            exp = exp_q.pop_front();
            check({tag, " read_data"}, rdata[d], exp);
            last_rd[d] = exp;
        end else begin
            check({tag, " data_hold"}, rdata[d], (ws == 0) ? 32'h0 : last_rd[d]);
        end
        check({tag, " align_err"}, 32'(aerr[d]), 32'(illegal(w, s)));
        if (w && !illegal(w, s)) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) model[d][widx][8*i +: 8] = dat[8*i +: 8];
        end
        @(negedge clk);
        ce[d] = 1'b0;
        #1;
        check({tag, " idle_after"}, 32'(stall[d]), 32'd0);
        @(negedge clk);
    endtask

    initial begin
`ifdef DATA_RAM_ALIGN_CHECK_EN
        align_en = 1'b1;
`else
        align_en = 1'b0;
`endif
        for (int d = 0; d < 3; d++) begin
            ce[d] = 1'b0; we[d] = 1'b0; sel[d] = 4'h0; addr[d] = '0; wdata[d] = '0;
            last_rd[d] = '0;
            for (int i = 0; i < (1 << AW); i++) model[d][i] = '0;
        end
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check("reset stall", 32'(stall[d]), 32'd0);
            check("reset data", rdata[d], 32'h0);
            check("reset align", 32'(aerr[d]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("idle stall", 32'(stall[0]), 32'd0);
            check("idle data", rdata[0], 32'h0);
            @(negedge clk);
        end

        access(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, "ws1 wr10");
        access(0, 1'b0, 4'b1111, 32'h10, 32'h0, "ws1 rd10");
        access(0, 1'b1, 4'b1111, 32'h20, 32'h11223344, "ws1 wr20");
        access(0, 1'b1, 4'b0100, 32'h20, 32'hAABBCCDD, "ws1 lane2");
        access(0, 1'b0, 4'b1111, 32'h20, 32'h0, "ws1 rd20");
        check("lane merge model", model[0][8], 32'h11BB3344);
        access(0, 1'b0, 4'b0001, 32'h20 + (32'd1 << (AW + 2)) + 32'd3, 32'h0, "ws1 alias");
        access(0, 1'b1, 4'b1111, 32'h50, 32'hCAFEF00D, "ws1 wr50");
        access(0, 1'b1, 4'b0101, 32'h50, 32'h11223344, "ws1 sel0101");
        access(0, 1'b0, 4'b1111, 32'h50, 32'h0, "ws1 rd50");
        access(0, 1'b1, 4'b1111, 32'h60, 32'h0BADF00D, "ws1 wr60");
        access(0, 1'b1, 4'b0000, 32'h60, 32'hFFFFFFFF, "ws1 sel0");
        access(0, 1'b0, 4'b1111, 32'h60, 32'h0, "ws1 rd60");

        access(1, 1'b1, 4'b1111, 32'h30, 32'h5A5A1234, "ws3 wr30");
        access(1, 1'b0, 4'b1111, 32'h30, 32'h0, "ws3 rd30");
        access(1, 1'b1, 4'b1111, 32'h40, 32'h00000000, "ws3 clr40");

        ce[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'b1111; addr[1] = 32'h40; wdata[1] = 32'h12345678;
        @(negedge clk);
        ce[1] = 1'b0;
        #1;
        check("midbusy stall_before", 32'(stall[1]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midbusy stall_async", 32'(stall[1]), 32'd0);
        check("midbusy data_cleared", rdata[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) last_rd[d] = '0;
        @(negedge clk);
        access(1, 1'b0, 4'b1111, 32'h40, 32'h0, "ws3 rd40");

        access(2, 1'b1, 4'b1111, 32'h70, 32'h87654321, "ws0 wr70");
        access(2, 1'b1, 4'b0011, 32'h70, 32'h0000FFFF, "ws0 lanes");
        access(2, 1'b0, 4'b1111, 32'h70, 32'h0, "ws0 rd70");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
